// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned ADDR_W      = $clog2(NUM_REGS);
  localparam int unsigned MAX_PENDING = 3;
  localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;

  // Busy test on a count, optionally discounting a retire landing this cycle.
  function automatic logic cnt_busy(input pend_cnt_t cnt, input logic retire);
    if (retire) begin
      cnt_busy = (cnt > CNT_W'(1));
    end else begin
      cnt_busy = (cnt != '0);
    end
  endfunction

endpackage : regfile_pkg

// File: rtl/pending_counter.sv
// Saturating up/down counter of outstanding writes for one register.
// inc and dec together cancel; overflow/underflow hold and flag err_c_o.
module pending_counter
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      inc_i,
  input  logic      dec_i,
  output pend_cnt_t cnt_o,
  output logic      err_c_o
);

  pend_cnt_t cnt_q;
  pend_cnt_t cnt_d;

  // Next count and same-cycle error flag.
  always_comb begin
    cnt_d   = cnt_q;
    err_c_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_W'(MAX_PENDING)) begin
        err_c_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        err_c_o = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pending_counter

// File: rtl/reg_file_scoreboard.sv
// 32x32 register file with per-register pending-write scoreboard.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write-back data
// to the read ports and drop busy in the retiring cycle.
module reg_file_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output reg_data_t rs_data,
  output reg_data_t rt_data,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_data_t wb_data,
  input  logic      issue_en,
  input  reg_addr_t issue_dest,
  output logic      rs_busy,
  output logic      rt_busy,
  output logic      stall,
  output logic      sb_err
);

  reg_data_t           mem_q [NUM_REGS];
  pend_cnt_t           cnt_c [NUM_REGS];
  logic [NUM_REGS-1:0] err_c;
  logic                sb_err_q;
  logic                sb_err_d;
  logic                wb_live_c;

  assign wb_live_c = wb_en && (wb_addr != '0);

  // Register storage; register 0 is never written and stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_live_c) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // Register 0 has no scoreboard entry.
  assign cnt_c[0] = '0;
  assign err_c[0] = 1'b0;

  // One pending counter per writable register.
  for (genvar g = 1; g < int'(NUM_REGS); g++) begin : g_cnt
    pending_counter u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (issue_en && (issue_dest == ADDR_W'(g))),
      .dec_i   (wb_en && (wb_addr == ADDR_W'(g))),
      .cnt_o   (cnt_c[g]),
      .err_c_o (err_c[g])
    );
  end

  // Sticky error accumulates any counter overflow/underflow.
  always_comb begin
    sb_err_d = sb_err_q | (|err_c);
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  // Read ports and busy flags, forced quiet while reset is held.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    if (!reset) begin
`ifdef REGFILE_BYPASS_EN
      if (rs_addr != '0) begin
        rs_data = (wb_live_c && (wb_addr == rs_addr)) ? wb_data : mem_q[rs_addr];
        rs_busy = cnt_busy(cnt_c[rs_addr], wb_live_c && (wb_addr == rs_addr));
      end
      if (rt_addr != '0) begin
        rt_data = (wb_live_c && (wb_addr == rt_addr)) ? wb_data : mem_q[rt_addr];
        rt_busy = cnt_busy(cnt_c[rt_addr], wb_live_c && (wb_addr == rt_addr));
      end
`else
      if (rs_addr != '0) begin
        rs_data = mem_q[rs_addr];
        rs_busy = cnt_busy(cnt_c[rs_addr], 1'b0);
      end
      if (rt_addr != '0) begin
        rt_data = mem_q[rt_addr];
        rt_busy = cnt_busy(cnt_c[rt_addr], 1'b0);
      end
`endif
    end
  end

  assign stall = rs_busy | rt_busy;

endmodule : reg_file_scoreboard

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Receiving end of the write-back path: a 32x32 general-purpose register file.
- Consumes the write-back stage's data/address/enable and serves the decode stage's two read ports.
- Per-register pending-write scoreboard: decode marks a destination pending at issue; write-back retires it.
- Drives busy/stall so decode can hold on RAW hazards.

Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 32, number of architectural registers (register 0 hardwired to zero)
- ADDR_W, 5, register address width, equal to log2(NUM_REGS)
- MAX_PENDING, 3, maximum outstanding writes tracked per register
- CNT_W, 2, pending counter width, ceil(log2(MAX_PENDING+1))

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data, combinational
- rt_data  out  DATA_W  read port B data, combinational
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back value
- issue_en  in  1  decode issued an instruction that will write issue_dest
- issue_dest  in  ADDR_W  destination being marked pending
- rs_busy  out  1  rs_addr has outstanding writes
- rt_busy  out  1  rt_addr has outstanding writes
- stall  out  1  rs_busy OR rt_busy
- sb_err  out  1  sticky scoreboard error (overflow or underflow)

Behaviour:
- Reset (sync, active-high, sampled at rising clk): all registers 0, all pending counters 0, sb_err 0. While reset is high, rs_data/rt_data are 0, busy/stall are 0, and the write/issue inputs are ignored.
- Write: on a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data. Writes to register 0 are discarded.
- Read: combinational, zero latency. Address 0 always returns 0.
- Counter, issue only: on issue_en=1, issue_dest!=0, cnt[issue_dest] increments.
  - If the counter is already MAX_PENDING, it holds and sb_err sets.
- Counter, retire only: on wb_en=1, wb_addr!=0, cnt[wb_addr] decrements.
  - If the counter is already 0, it holds, sb_err sets, and the data write still occurs.
- Counter, simultaneous issue and wb to the same nonzero register: count unchanged, no error, data is written.
- Counter, simultaneous issue and wb to different registers: both updates apply independently.
- Issue to register 0 is ignored and does not set sb_err.
- Busy: rs_busy = (rs_addr!=0) && effective count of rs_addr != 0; rt_busy likewise. "Effective" is defined under Optional Feature.
- sb_err stays at 1 until reset.
- Reset mid-operation: all pending state is discarded. Counters do not wait for in-flight write-backs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: a read whose address matches a same-cycle write (wb_en=1, wb_addr==read addr, addr!=0) returns wb_data, not the stored value.
  - Effective count for busy = stored count minus 1 when that same-cycle retire targets the address. Busy therefore drops in the write-back cycle.
- Undefined: reads return the stored value, so the written value is visible the cycle after.
  - Busy uses the stored count. Busy drops one cycle after the retiring write-back.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS, MAX_PENDING, CNT_W
  - typedefs reg_addr_t, reg_data_t, pend_cnt_t
- One sub-module: pending_counter, a saturating up/down counter with inc, dec and err outputs. It is instantiated per register 1..NUM_REGS-1 via generate. Register 0 has no counter.

Test Plan:
- Reset high one cycle, then read rs_addr=5, rt_addr=31 -> both data 0, stall=0, sb_err=0.
- wb_en=1, wb_addr=0, wb_data=0xDEADBEEF; next cycle read rs_addr=0 -> 0. Then wb_addr=7, data 0x12345678; next cycle read rs_addr=7 -> 0x12345678.
- issue_en, issue_dest=9; next cycle rs_addr=9 -> rs_busy=1, stall=1. wb_en, wb_addr=9, data 0xA5A5A5A5 and rs_addr=9 in the same cycle:
  - With REGFILE_BYPASS_EN: rs_data=0xA5A5A5A5, stall=0 that cycle.
  - Without REGFILE_BYPASS_EN: rs_data=old value, stall=1; the next cycle gives 0xA5A5A5A5, stall=0.
- Issue to register 3 four times -> count saturates at 3, sb_err=1. Three write-backs to 3 -> rt_busy for rt_addr=3 clears, sb_err stays 1.
- wb to register 12 with count 0 -> data written, sb_err=1. Then reset -> sb_err=0, reg 12 reads 0.
- Same-cycle issue_dest=4 and wb_addr=4 with count 1 -> count stays 1, rs_busy(4)=1, no error. Assert reset with counts nonzero -> all busy 0 the next cycle.
